voda_code_transmitter: RTL
==========================

VODA_CODE_TRANSMITTER -- requirements
Module: voda_code_transmitter

Parameters
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the sync-pattern width in bits.
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011, giving the sync pattern sent MSB-first.
REQ-003 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits.

Interface
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  frame request, sampled on a rising clk edge.
REQ-007 data_in  input  DATA_W  payload, captured with an accepted start.
REQ-008 x  output  1  serial line bit.
REQ-009 tx_en  output  1  high while x carries frame bits.
REQ-010 ready  output  1  high when a start will be accepted.
REQ-011 done  output  1  one-cycle pulse at the end of each frame.
REQ-012 frames_sent  output  10  count of completed frames.

Function
REQ-013 The FSM SHALL have four states: IDLE, PRE, DATA and GUARD.
REQ-014 ready SHALL equal (state == IDLE) combinationally; every other output SHALL be registered.
REQ-015 In IDLE, an edge with start=1 SHALL latch data_in into the shift register, load the bit index and move to PRE; start=0 SHALL leave the FSM in IDLE.
REQ-016 start SHALL be ignored in every state other than IDLE; a frame in progress SHALL NOT be altered or restarted.
REQ-017 In the cycle after acceptance, x SHALL equal PATTERN[PAT_W-1], and tx_en SHALL be 1, giving a latency of 1 cycle.
REQ-018 PRE SHALL last PAT_W cycles and drive PATTERN MSB-first, then move to DATA.
REQ-019 DATA SHALL last DATA_W cycles and drive the latched payload MSB-first, then move to GUARD.
REQ-020 GUARD SHALL last 1 cycle with x=0 and tx_en=1, then move to IDLE.
REQ-021 The frame length SHALL be PAT_W+DATA_W+1 cycles, which is 13 with the defaults.
REQ-022 On the GUARD->IDLE edge, done SHALL be 1 for exactly one cycle and frames_sent SHALL increment by 1.
REQ-023 frames_sent SHALL wrap modulo 1024 (1023 -> 0) with no flag.
REQ-024 In IDLE, x SHALL be 0 and tx_en SHALL be 0.
REQ-025 Back-to-back: a start in the done cycle, where ready=1, SHALL be accepted, leaving exactly one idle cycle (x=0, tx_en=0) between frames.
REQ-026 A change of data_in after acceptance SHALL NOT affect the frame in progress.
REQ-027 The bit index width SHALL be sized for max(PAT_W, DATA_W), with no overflow for legal parameters.

Reset
REQ-028 rst=0 SHALL immediately force, regardless of clk: state=IDLE, x=0, tx_en=0, done=0, frames_sent=0, shift register=0, index=0.
REQ-029 rst asserted mid-frame SHALL abort the frame with no done pulse and no count increment.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-031 Reset: hold rst=0 for 50 time units with random start -> x=0, tx_en=0, ready=1, done=0, frames_sent=0 throughout.
REQ-032 Single frame: start=1 for one cycle with data_in=8'hA5 -> the next 13 x bits are 1,0,1,1,1,0,1,0,0,1,0,1,0 with tx_en=1, then done=1 and frames_sent=1.
REQ-033 Busy start plus data change: start=1 and data_in=8'hFF on every cycle of a frame carrying 8'h3C -> payload bits 0,0,1,1,1,1,0,0 unchanged and no restart; the next frame starts only after the done cycle.
REQ-034 Back-to-back: start held at 1 continuously -> frames of 13 cycles separated by exactly one idle cycle, with frames_sent incrementing once per frame.
REQ-035 Mid-frame reset: rst=0 during the 6th bit -> x=0 and tx_en=0 at once, no done pulse, frames_sent=0, and a start after release sends a complete frame.
REQ-036 Wrap: 1024 consecutive frames -> frames_sent reads 1023, then 0; the bench cross-checks each x stream against a pattern-detector model.

Source files
------------

// File: rtl/voda_code_transmitter.sv
// Serial frame transmitter: sync pattern, MSB-first payload, one guard bit.
// Counts completed frames and pulses done on each frame end.
module voda_code_transmitter #(
  parameter int unsigned        PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
  parameter int unsigned        DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              x,
  output logic              tx_en,
  output logic              ready,
  output logic              done,
  output logic [9:0]        frames_sent
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned MAX_W = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int unsigned IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                x_q, x_d;
  logic                tx_en_q, tx_en_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    frames_q, frames_d;
  logic [PAT_W-1:0]    pat_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      x_q      <= 1'b0;
      tx_en_q  <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      x_q      <= x_d;
      tx_en_q  <= tx_en_d;
      done_q   <= done_d;
      frames_q <= frames_d;
    end
  end

  // Next state: idx counts down within PRE and DATA; payload shifts left in DATA.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRE;
          shift_d = data_in;
          idx_d   = IDX_W'(PAT_W - 1);
        end
      end
      PRE: begin
        if (idx_q == '0) begin
          state_d = DATA;
          idx_d   = IDX_W'(DATA_W - 1);
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DATA: begin
        if (idx_q == '0) begin
          state_d = GUARD;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          shift_d = shift_q << 1;
        end
      end
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so the line bit tracks state with no lag.
  always_comb begin
    x_d      = 1'b0;
    tx_en_d  = 1'b0;
    done_d   = 1'b0;
    frames_d = frames_q;
    pat_sh   = PATTERN >> idx_d;
    case (state_d)
      PRE: begin
        x_d     = pat_sh[0];
        tx_en_d = 1'b1;
      end
      DATA: begin
        x_d     = shift_d[DATA_W-1];
        tx_en_d = 1'b1;
      end
      GUARD:   tx_en_d = 1'b1;
      default: tx_en_d = 1'b0;
    endcase
    if (state_q == GUARD) begin
      done_d   = 1'b1;
      frames_d = frames_q + CNT_W'(1);
    end
  end

  assign ready       = (state_q == IDLE);
  assign x           = x_q;
  assign tx_en       = tx_en_q;
  assign done        = done_q;
  assign frames_sent = frames_q;

endmodule
